lsu_access: RTL and testbench
=============================

// Module: lsu_access
// PURPOSE
//  Load/store unit directly downstream of the integer ALU in the execute path. Takes the
//  ALU result as effective address plus rs2 as store data, runs one data-bus transaction
//  via req/ack handshake, and returns the aligned, sign/zero-extended load result.
//  Flags misaligned accesses, illegal funct3, bus errors and bus timeouts; one access in flight.
// PARAMETERS
//  Width         32  datapath/address width; only 32 supported (4 byte lanes)
//  TimeoutCycles 64  max cycles mem_req waits for mem_ack before fault; 0 = no timeout
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      request an access; sampled only in IDLE
//  store      in   1      1 = store, 0 = load
//  funct3     in   3      ISA funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
//  addr       in   Width  effective address (ALU output c)
//  wdata      in   Width  store data (rs2)
//  busy       out  1      high in BUS and RESP states
//  done       out  1      one-cycle completion pulse
//  rdata      out  Width  load result; valid with done, held until next done
//  misaligned out  1      valid with done: address misaligned for size
//  fault      out  1      valid with done: illegal funct3, mem_err or timeout
//  mem_req    out  1      bus request, held until mem_ack or mem_err or timeout
//  mem_we     out  1      bus write enable
//  mem_addr   out  Width  word address {addr[Width-1:2],2'b00}
//  mem_be     out  4      byte enables
//  mem_wdata  out  Width  lane-replicated store data
//  mem_ack    in   1      bus completion, sampled while mem_req high
//  mem_err    in   1      bus error, sampled while mem_req high; wins over mem_ack
//  mem_rdata  in   Width  read word, valid with mem_ack
// BEHAVIOUR
//  Reset (rst_n low at edge): state IDLE; every output 0 incl. rdata; timeout counter 0.
//  Reset mid-transaction drops mem_req at that edge; no done is produced.
//  States: IDLE -> BUS (start, legal, aligned); IDLE -> RESP (start, illegal or misaligned);
//   BUS -> RESP (mem_ack | mem_err | timeout); RESP -> IDLE unconditionally.
//  In IDLE, start latches store/funct3/addr/wdata; start while busy is ignored.
//  Legal: load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}; else fault=1.
//  Alignment: half needs addr[0]=0, word needs addr[1:0]=00; misaligned=1, no bus cycle.
//  Illegal funct3 takes priority over misaligned (only fault set).
//  Lane L=addr[1:0]. mem_be: byte 4'b0001<<L, half 4'b0011<<L, word 4'b1111; same for loads.
//  mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  Load: shift mem_rdata right 8*L; LB/LH sign-extend, LBU/LHU zero-extend, LW as is.
//  Stores and faulted/misaligned accesses leave rdata unchanged.
//  mem_req/mem_we/mem_addr/mem_be/mem_wdata registered, stable for whole BUS state.
//  Latency: start at edge N -> mem_req high N+1; ack sampled at edge M -> done high M+1.
//   Zero-wait bus (ack in first req cycle) -> done at N+2. Misaligned/illegal -> done at N+1.
//  Timeout: counter clears on BUS entry, +1 per BUS cycle without ack/err; reaching
//   TimeoutCycles -> RESP with fault=1, rdata held. mem_err -> fault=1, rdata held.
//  done, misaligned, fault are single-cycle pulses in RESP; 0 in all other states.
//  Next start accepted the cycle after done (back-to-back issue every 3 cycles, zero-wait bus).
// TESTING
//  LB addr=0x1003, mem_rdata=0x80AA55CC, ack 1st cycle -> mem_be=1000, done at N+2, rdata=0xFFFFFF80
//  SH addr=0x2002 wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000
//  LW addr=0x1001 -> no mem_req ever, done at N+1, misaligned=1, fault=0, rdata unchanged
//  LHU addr=0x0006, ack after 5 wait cycles, mem_rdata=0xF00D1234 -> rdata=0x0000F00D, busy throughout
//  TimeoutCycles=4, no ack -> mem_req high exactly 4 cycles, then done with fault=1; err+ack together -> fault=1
//  rst_n low 2 cycles after start while waiting -> mem_req 0 next edge, no done; new LW 0x10 completes normally

Source files
------------

// File: rtl/lsu_access.sv
// Load/store access unit: one data-bus transaction per access with lane steering and load extension.
// Alignment/illegal faults resolve without a bus cycle; timeout bounds the wait for mem_ack.
module lsu_access #(
  parameter int Width         = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             store,
  input  logic [2:0]       funct3,
  input  logic [Width-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] rdata,
  output logic             misaligned,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [Width-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [Width-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic             mem_err,
  input  logic [Width-1:0] mem_rdata
);

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic              store_q;
  logic              fault_q;
  logic              mis_q;
  logic [CntW-1:0]   cnt;

  logic              legal_in;
  logic              mis_in;
  logic [3:0]        be_in;
  logic [Width-1:0]  wdata_rep;
  logic              timeout;
  logic [Width-1:0]  shifted;
  logic [Width-1:0]  load_val;

  // Decode of the incoming request, used only on the IDLE edge that accepts it.
  always_comb begin
    legal_in  = 1'b0;
    mis_in    = 1'b0;
    be_in     = 4'b0000;
    wdata_rep = wdata;
    if (store)
      legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      legal_in = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b00: begin
        be_in     = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_in     = 4'b0011 << addr[1:0];
        wdata_rep = {2{wdata[15:0]}};
        mis_in    = addr[0];
      end
      default: begin
        be_in     = 4'b1111;
        wdata_rep = wdata;
        mis_in    = (addr[1:0] != 2'b00);
      end
    endcase
    // Illegal funct3 masks misalignment so only fault is reported.
    mis_in = mis_in & legal_in;
  end

  assign timeout = (TimeoutCycles != 0) && (cnt == CntW'(TimeoutCycles - 1));

  always_comb begin
    shifted  = mem_rdata >> {lane_q, 3'b000};
    load_val = shifted;
    case (funct3_q)
      3'b000:  load_val = {{(Width-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{(Width-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {{(Width-8){1'b0}}, shifted[7:0]};
      3'b101:  load_val = {{(Width-16){1'b0}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = (legal_in && !mis_in) ? BUS : RESP;
      end
      BUS: begin
        if (mem_ack || mem_err || timeout)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      store_q   <= 1'b0;
      fault_q   <= 1'b0;
      mis_q     <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            funct3_q <= funct3;
            lane_q   <= addr[1:0];
            store_q  <= store;
            fault_q  <= !legal_in;
            mis_q    <= mis_in;
            cnt      <= '0;
            if (legal_in && !mis_in) begin
              mem_req   <= 1'b1;
              mem_we    <= store;
              mem_addr  <= {addr[Width-1:2], 2'b00};
              mem_be    <= be_in;
              mem_wdata <= wdata_rep;
            end
          end
        end
        BUS: begin
          if (mem_ack || mem_err || timeout) begin
            // Error beats ack; a faulted access never touches rdata.
            if (mem_err || !mem_ack)
              fault_q <= 1'b1;
            else if (!store_q)
              rdata <= load_val;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == BUS) || (state == RESP);
  assign done       = (state == RESP);
  assign misaligned = (state == RESP) && mis_q;
  assign fault      = (state == RESP) && fault_q;

endmodule

// File: tb/tb_lsu_access.sv
// Bench for lsu_access: directed vector table, randomized accesses against a byte-level model,
// plus reset-in-flight and bus-timeout sequences (the latter on a short-timeout instance).
module tb_lsu_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_ack, mem_err, ack2, err2;

  logic        busy, done, misaligned, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        busy2, done2, misaligned2, fault2, mem_req2, mem_we2;
  logic [31:0] rdata2, mem_addr2, mem_wdata2;
  logic [3:0]  mem_be2;

  int n_vec = 0;
  int n_mis = 0;
  logic [31:0] model_rd = 32'h0;

  always #5 clk = ~clk;

  lsu_access #(.Width(32), .TimeoutCycles(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .store(store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  lsu_access #(.Width(32), .TimeoutCycles(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .store(store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy2), .done(done2), .rdata(rdata2),
    .misaligned(misaligned2), .fault(fault2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_be(mem_be2), .mem_wdata(mem_wdata2),
    .mem_ack(ack2), .mem_err(err2), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          wt;
    logic        err;
    logic        poke;
    logic        exp_bus;
    logic        exp_mis;
    logic        exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } acc_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic st, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mr, input int wt,
                              input logic er, input logic pk, input logic bus, input logic mis,
                              input logic flt, input logic [3:0] be, input logic [31:0] ewd,
                              input logic [31:0] erd);
    acc_t r;
    r.store = st; r.f3 = f; r.addr = a; r.wdata = wd; r.mrd = mr; r.wt = wt;
    r.err = er; r.poke = pk; r.exp_bus = bus; r.exp_mis = mis; r.exp_fault = flt;
    r.exp_be = be; r.exp_wd = ewd; r.exp_rd = erd;
    return r;
  endfunction

  // Reference: access size in bytes, byte-by-byte gather and extension.
  function automatic acc_t model(input acc_t v, input logic [31:0] prev);
    acc_t r;
    int size;
    int lane;
    logic legal;
    logic [31:0] val;
    r = v;
    lane = int'(v.addr[1:0]);
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    legal = v.store ? (v.f3 <= 3'd2)
                    : (v.f3 == 3'd0 || v.f3 == 3'd1 || v.f3 == 3'd2 || v.f3 == 3'd4 || v.f3 == 3'd5);
    r.exp_rd = prev; r.exp_be = 4'b0; r.exp_wd = 32'h0;
    r.exp_mis = 1'b0; r.exp_fault = 1'b0; r.exp_bus = 1'b0;
    if (!legal) begin
      r.exp_fault = 1'b1;
    end else if ((lane % size) != 0) begin
      r.exp_mis = 1'b1;
    end else begin
      r.exp_bus = 1'b1;
      r.exp_fault = v.err;
      for (int i = 0; i < size; i++) r.exp_be[lane + i] = 1'b1;
      for (int i = 0; i < 4; i++) r.exp_wd[8*i +: 8] = v.wdata[8*(i % size) +: 8];
      if (!v.store && !v.err) begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val[8*i +: 8] = v.mrd[8*(lane + i) +: 8];
        if (!v.f3[2] && size < 4 && val[8*size - 1])
          for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
        r.exp_rd = val;
      end
    end
    return r;
  endfunction

  task automatic run_access(input acc_t v);
    store = v.store; funct3 = v.f3; addr = v.addr; wdata = v.wdata; mem_rdata = v.mrd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.exp_bus) begin
      chk1("req", mem_req, 1'b1);
      chk1("we", mem_we, v.store);
      chk32("maddr", mem_addr, v.addr & 32'hFFFF_FFFC);
      chk32("be", {28'h0, mem_be}, {28'h0, v.exp_be});
      if (v.store) chk32("wdat", mem_wdata, v.exp_wd);
      chk1("done_early", done, 1'b0);
      for (int i = 0; i < v.wt; i++) begin
        if (i == 0 && v.poke) begin
          start = 1'b1; addr = ~v.addr; store = ~v.store;
        end
        @(negedge clk);
        start = 1'b0; addr = v.addr; store = v.store;
        chk1("req_hold", mem_req, 1'b1);
        chk1("busy_wait", busy, 1'b1);
        chk1("done_wait", done, 1'b0);
        if (v.poke) chk32("maddr_hold", mem_addr, v.addr & 32'hFFFF_FFFC);
      end
      mem_ack = 1'b1; mem_err = v.err;
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0;
    end else begin
      chk1("noreq", mem_req, 1'b0);
    end
    chk1("done", done, 1'b1);
    chk1("mis", misaligned, v.exp_mis);
    chk1("fault", fault, v.exp_fault);
    chk32("rdata", rdata, v.exp_rd);
    chk1("req_off", mem_req, 1'b0);
    chk1("busy_resp", busy, 1'b1);
    @(negedge clk);
    chk1("done_pulse", done, 1'b0);
    chk1("idle", busy, 1'b0);
    model_rd = v.exp_rd;
  endtask

  acc_t tbl[13];

  initial begin
    acc_t v;
    int reqc, seen, cyc;

    tbl[0]  = mk(0, 3'd0, 32'h1003, 32'h0,        32'h80AA55CC, 0, 0, 0, 1, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    tbl[1]  = mk(1, 3'd1, 32'h2002, 32'h1234ABCD, 32'h0,        0, 0, 0, 1, 0, 0, 4'b1100, 32'hABCDABCD, 32'hFFFFFF80);
    tbl[2]  = mk(0, 3'd2, 32'h1001, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF80);
    tbl[3]  = mk(0, 3'd5, 32'h0006, 32'h0,        32'hF00D1234, 5, 0, 1, 1, 0, 0, 4'b1100, 32'h0,        32'h0000F00D);
    tbl[4]  = mk(0, 3'd2, 32'h1000, 32'h0,        32'hDEADBEEF, 1, 1, 0, 1, 0, 1, 4'b1111, 32'h0,        32'h0000F00D);
    tbl[5]  = mk(0, 3'd6, 32'h0003, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h0000F00D);
    tbl[6]  = mk(0, 3'd1, 32'h1002, 32'h0,        32'h80017FFF, 0, 0, 0, 1, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001);
    tbl[7]  = mk(0, 3'd4, 32'h1001, 32'h0,        32'h123456F0, 1, 0, 0, 1, 0, 0, 4'b0010, 32'h0,        32'h00000056);
    tbl[8]  = mk(1, 3'd0, 32'h0007, 32'h000000AB, 32'h0,        0, 0, 0, 1, 0, 0, 4'b1000, 32'hABABABAB, 32'h00000056);
    tbl[9]  = mk(1, 3'd2, 32'h0008, 32'hCAFEF00D, 32'h0,        2, 0, 0, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h00000056);
    tbl[10] = mk(1, 3'd1, 32'h0003, 32'h5555AAAA, 32'h0,        0, 0, 0, 0, 1, 0, 4'b0000, 32'h0,        32'h00000056);
    tbl[11] = mk(1, 3'd3, 32'h0000, 32'h5555AAAA, 32'h0,        0, 0, 0, 0, 0, 1, 4'b0000, 32'h0,        32'h00000056);
    tbl[12] = mk(0, 3'd2, 32'h0010, 32'h0,        32'h01020304, 2, 0, 0, 1, 0, 0, 4'b1111, 32'h0,        32'h01020304);

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; store = 1'b0; funct3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;
    mem_ack = 1'b0; mem_err = 1'b0; ack2 = 1'b0; err2 = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_be", {28'h0, mem_be}, 32'h0);
    chk1("rst_fault", fault, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_access(tbl[i]);

    for (int i = 0; i < 300; i++) begin
      v.store = 1'($urandom % 2);
      v.f3    = 3'($urandom % 8);
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.mrd   = $urandom;
      v.wt    = int'($urandom % 4);
      v.err   = ($urandom % 6) == 0;
      v.poke  = ($urandom % 5) == 0;
      v = model(v, model_rd);
      run_access(v);
    end

    // Reset while waiting on the bus: request drops, no completion.
    store = 1'b0; funct3 = 3'd2; addr = 32'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("rst_mid_req_before", mem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("rst_mid_req", mem_req, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_done", done, 1'b0);
    chk32("rst_mid_rdata", rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst_mid_nodone", done, 1'b0);
    end
    model_rd = 32'h0;
    v = mk(0, 3'd2, 32'h10, 32'h0, 32'hA5A50F0F, 1, 0, 0, 0, 0, 0, 4'b0, 32'h0, 32'h0);
    v = model(v, model_rd);
    run_access(v);

    // Timeout on the 4-cycle instance with no ack ever.
    store = 1'b0; funct3 = 3'd2; addr = 32'h20; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    reqc = 0; seen = 0; cyc = 0;
    while (cyc < 20 && seen == 0) begin
      if (mem_req2) reqc++;
      if (done2) begin
        seen = 1;
        chk1("to_fault", fault2, 1'b1);
        chk1("to_mis", misaligned2, 1'b0);
        chk32("to_rdata", rdata2, 32'h0);
        chk1("to_busy", busy2, 1'b1);
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    chk32("to_seen", seen, 32'd1);
    chk32("to_req_cycles", reqc, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
